// File: rtl/atconv_pkg.sv
// Shared widths, dump FSM states and buffer payload for the ATCONV result-memory arbiter.
package atconv_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 13;
  localparam int unsigned L2_AW     = 10;
  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dump_word_t;

endpackage

// File: rtl/layer_dump_fifo.sv
// Two-entry {addr, data} buffer between the memory read port and the dump stream.
module layer_dump_fifo
  import atconv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  dump_word_t i_word,
  output dump_word_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam logic [1:0] CNT_FULL = 2'(BUF_DEPTH);

  dump_word_t r_mem [BUF_DEPTH];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;

  logic       w_push;
  logic       w_pop;

  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign w_pop  = i_pop & (r_cnt != 2'd0);
  assign w_push = i_push & ((r_cnt != CNT_FULL) | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_word;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/layer_mem_arbiter.sv
// Shares the layer1/layer2 memory port between the ATCONV core (always wins)
// and a host dump engine that reads a programmed window in the idle slots.
module layer_mem_arbiter
  import atconv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_csel,
  input  logic              core_crd,
  input  logic [ADDR_W-1:0] core_caddr_rd,
  output logic [DATA_W-1:0] core_cdata_rd,
  input  logic              core_cwr,
  input  logic [ADDR_W-1:0] core_caddr_wr,
  input  logic [DATA_W-1:0] core_cdata_wr,
  output logic              mem_csel,
  output logic              mem_crd,
  output logic [ADDR_W-1:0] mem_caddr_rd,
  input  logic [DATA_W-1:0] mem_cdata_rd,
  output logic              mem_cwr,
  output logic [ADDR_W-1:0] mem_caddr_wr,
  output logic [DATA_W-1:0] mem_cdata_wr,
  input  logic              dump_start,
  input  logic              dump_sel,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              dump_abort,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr
);

  dump_state_e       r_state;
  dump_state_e       w_state_nxt;
  logic              r_sel;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_sum;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W:0]   w_issued_nxt;
  logic              w_pop;
  logic              w_space;
  logic              w_grant;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  dump_word_t        w_head;
  dump_word_t        w_push_word;

  // Writes are never arbitrated; the core read data is a straight return path.
  assign mem_cwr       = core_cwr;
  assign mem_caddr_wr  = core_caddr_wr;
  assign mem_cdata_wr  = core_cdata_wr;
  assign core_cdata_rd = mem_cdata_rd;

  // Window address wraps inside the selected layer; layer2 keeps upper bits zero.
  assign w_sum      = r_base + r_issued[ADDR_W-1:0];
  assign w_cur_addr = r_sel ? {{(ADDR_W-L2_AW){1'b0}}, w_sum[L2_AW-1:0]} : w_sum;

  assign w_pop   = ~w_empty & dump_ready;
  assign w_space = ~w_full | w_pop;
  assign w_grant = (r_state == RUN) && (r_issued < r_len) && w_space && !dump_abort
                   && !core_crd && (!core_cwr || (core_csel == r_sel));

  assign w_issued_nxt = r_issued + (ADDR_W+1)'(w_grant);

  always_comb begin
    mem_csel     = core_csel;
    mem_crd      = core_crd;
    mem_caddr_rd = core_caddr_rd;
    if (w_grant) begin
      mem_csel     = r_sel;
      mem_crd      = 1'b1;
      mem_caddr_rd = w_cur_addr;
    end
  end

  // Completion is looked ahead one cycle so done follows the last accept directly.
  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        if (dump_start) begin
          w_state_nxt = (dump_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (dump_abort) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (w_issued_nxt == r_len) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dump_abort) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (w_empty || (!w_full && w_pop)) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_sel    <= 1'b0;
      r_base   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == DONE);
      if ((r_state == IDLE) && dump_start) begin
        r_sel    <= dump_sel;
        r_base   <= dump_base;
        r_len    <= dump_len;
        r_issued <= '0;
      end else begin
        r_issued <= w_issued_nxt;
      end
    end
  end

  assign w_push_word = '{addr: w_cur_addr, data: mem_cdata_rd};

  layer_dump_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_grant),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_word  (w_push_word),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign dump_busy  = r_busy;
  assign dump_done  = r_done;
  assign dump_valid = ~w_empty;
  assign dump_data  = w_head.data;
  assign dump_addr  = w_head.addr;

endmodule
